// File: rtl/fp32_divider.sv
// fp32_divider: iterative IEEE-754 binary32 divider computing in0 / in1.
// The mantissa quotient comes from a radix-2 restoring divider, one bit per cycle.
// It is rounded to nearest-even. Denormal operands are flushed to signed zero.
// Latency is fixed at 29 cycles from acceptance to done for every operand class.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, accepted only while busy=0
//   in0    dividend (binary32)
//   in1    divisor (binary32)
//   busy   high from the cycle after acceptance through the done cycle
//   done   one-cycle pulse; out/flags valid in that cycle
//   out    quotient, held until the next done
//   flags  {inv, dz, ovf, unf}, held with out
module fp32_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic [3:0]  flags
);

  typedef enum logic [2:0] {StIdle, StUnpack, StDivide, StRound, StDone} state_e;

  state_e            state;
  logic [31:0]       opa, opb;
  logic              sign;
  logic signed [9:0] exp;
  logic [23:0]       mb;
  logic [24:0]       rem;
  logic [25:0]       quo;
  logic [4:0]        cnt;
  logic              special;
  logic [31:0]       spec_out;
  logic [3:0]        spec_flags;

  // Special-case classification of the latched operands, highest priority first.
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, res_sign;
  logic        cls_special;
  logic [31:0] cls_out;
  logic [3:0]  cls_flags;

  always_comb begin
    a_zero      = (opa[30:23] == 8'h00);
    b_zero      = (opb[30:23] == 8'h00);
    a_inf       = (opa[30:23] == 8'hFF) && (opa[22:0] == 23'd0);
    b_inf       = (opb[30:23] == 8'hFF) && (opb[22:0] == 23'd0);
    a_nan       = (opa[30:23] == 8'hFF) && (opa[22:0] != 23'd0);
    b_nan       = (opb[30:23] == 8'hFF) && (opb[22:0] != 23'd0);
    res_sign    = opa[31] ^ opb[31];
    cls_special = 1'b1;
    cls_out     = 32'd0;
    cls_flags   = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      cls_out   = 32'h7FC0_0000;
      cls_flags = 4'b1000;
    end else if (a_inf) begin
      cls_out = {res_sign, 8'hFF, 23'd0};
    end else if (b_inf) begin
      cls_out = {res_sign, 31'd0};
    end else if (b_zero) begin
      cls_out   = {res_sign, 8'hFF, 23'd0};
      cls_flags = 4'b0100;
    end else if (a_zero) begin
      cls_out = {res_sign, 31'd0};
    end else begin
      cls_special = 1'b0;
    end
  end

  // One restoring step. rem < 2*mb always holds, so 25 bits suffice after doubling.
  logic [25:0] diff;
  logic        diff_neg;
  logic [24:0] rem_next;

  always_comb begin
    diff     = {1'b0, rem} - {2'b00, mb};
    diff_neg = diff[25];
    rem_next = diff_neg ? {rem[23:0], 1'b0} : {diff[23:0], 1'b0};
  end

  // Normalise, round to nearest-even, then range-check the exponent.
  logic [23:0]       rnd_m;
  logic              rnd_g, rnd_s, rnd_up;
  logic [24:0]       rnd_sum;
  logic signed [9:0] rnd_exp;
  logic [22:0]       rnd_frac;
  logic [31:0]       res_out;
  logic [3:0]        res_flags;

  always_comb begin
    if (quo[25]) begin
      rnd_m   = quo[25:2];
      rnd_g   = quo[1];
      rnd_s   = quo[0] | (rem != 25'd0);
      rnd_exp = exp;
    end else begin
      rnd_m   = quo[24:1];
      rnd_g   = quo[0];
      rnd_s   = (rem != 25'd0);
      rnd_exp = exp - 10'sd1;
    end
    rnd_up   = rnd_g & (rnd_s | rnd_m[0]);
    rnd_sum  = {1'b0, rnd_m} + {24'd0, rnd_up};
    rnd_frac = rnd_sum[22:0];
    if (rnd_sum[24]) begin
      rnd_frac = rnd_sum[23:1];
      rnd_exp  = rnd_exp + 10'sd1;
    end
    res_flags = 4'b0000;
    if (special) begin
      res_out   = spec_out;
      res_flags = spec_flags;
    end else if (rnd_exp >= 10'sd255) begin
      res_out   = {sign, 8'hFF, 23'd0};
      res_flags = 4'b0010;
    end else if (rnd_exp <= 10'sd0) begin
      res_out   = {sign, 31'd0};
      res_flags = 4'b0001;
    end else begin
      res_out = {sign, rnd_exp[7:0], rnd_frac};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      out        <= 32'd0;
      flags      <= 4'd0;
      opa        <= 32'd0;
      opb        <= 32'd0;
      sign       <= 1'b0;
      exp        <= 10'sd0;
      mb         <= 24'd0;
      rem        <= 25'd0;
      quo        <= 26'd0;
      cnt        <= 5'd0;
      special    <= 1'b0;
      spec_out   <= 32'd0;
      spec_flags <= 4'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            opa   <= in0;
            opb   <= in1;
            busy  <= 1'b1;
            state <= StUnpack;
          end
        end
        StUnpack: begin
          sign       <= res_sign;
          exp        <= $signed({2'b00, opa[30:23]}) - $signed({2'b00, opb[30:23]}) + 10'sd127;
          rem        <= {2'b01, opa[22:0]};
          mb         <= {1'b1, opb[22:0]};
          quo        <= 26'd0;
          cnt        <= 5'd25;
          special    <= cls_special;
          spec_out   <= cls_out;
          spec_flags <= cls_flags;
          state      <= StDivide;
        end
        StDivide: begin
          quo <= {quo[24:0], ~diff_neg};
          rem <= rem_next;
          if (cnt == 5'd0) begin
            state <= StRound;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        StRound: begin
          out   <= res_out;
          flags <= res_flags;
          done  <= 1'b1;
          state <= StDone;
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider.sv
// tb_fp32_divider: directed and randomized checks of fp32_divider against a
// behavioural reference computed with integer division from the operand fields.
module tb_fp32_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in0, in1;
  logic        busy, done;
  logic [31:0] out;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;

  fp32_divider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in0   (in0),
    .in1   (in1),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .flags (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Exact quotient ma*2^25/mb via 64-bit division, then RNE rounding of the value.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] o, output logic [3:0] f);
    int     ea, eb, e;
    bit     s, az, bz, ai, bi, an, bn, g, st;
    longint ma, mb, num, q, r, m;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    f  = 4'b0000;
    if (an || bn || (az && bz) || (ai && bi)) begin
      o = 32'h7FC0_0000; f = 4'b1000; return;
    end
    if (ai) begin o = {s, 8'hFF, 23'd0}; return; end
    if (bi) begin o = {s, 31'd0}; return; end
    if (bz) begin o = {s, 8'hFF, 23'd0}; f = 4'b0100; return; end
    if (az) begin o = {s, 31'd0}; return; end
    ma  = longint'({1'b1, a[22:0]});
    mb  = longint'({1'b1, b[22:0]});
    num = ma << 25;
    q   = num / mb;
    r   = num % mb;
    e   = ea - eb + 127;
    if (q >= (longint'(1) << 25)) begin
      m  = q >> 2;
      g  = ((q >> 1) & 1) != 0;
      st = ((q & 1) != 0) || (r != 0);
    end else begin
      e  = e - 1;
      m  = q >> 1;
      g  = (q & 1) != 0;
      st = (r != 0);
    end
    if (g && (st || ((m & 1) != 0))) m = m + 1;
    if (m == (longint'(1) << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      o = {s, 8'hFF, 23'd0}; f = 4'b0010;
    end else if (e <= 0) begin
      o = {s, 31'd0}; f = 4'b0001;
    end else begin
      o = {s, e[7:0], m[22:0]};
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] fr;
    int          k;
    k  = $urandom_range(0, 11);
    fr = 23'($urandom);
    if ($urandom_range(0, 5) == 0) fr = 23'd0;
    case (k)
      0: e = 8'h00;
      1: begin
        e = 8'hFF;
        if ($urandom_range(0, 1) == 0) fr = 23'd0;
      end
      2: e = 8'($urandom_range(200, 254));
      3: e = 8'($urandom_range(1, 50));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, fr};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of T+30.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want_o,
                        input logic [3:0] want_f, input string tag);
    int lat;
    int busy_low;
    start = 1'b1; in0 = a; in1 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in0 = $urandom; in1 = $urandom;
    lat = 1; busy_low = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_low++;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_low++;
    check({tag, "_lat"}, 32'(lat), 32'd29);
    check({tag, "_out"}, out, want_o);
    check({tag, "_flags"}, {28'd0, flags}, {28'd0, want_f});
    check({tag, "_busy"}, 32'(busy_low), 32'd0);
    @(negedge clk);
    check({tag, "_idle"}, {31'd0, busy | done}, 32'd0);
  endtask

  logic [31:0] dir_a [13] = '{32'h40C00000, 32'hBF800000, 32'h3F800000, 32'h3F800000,
                              32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F7FFFFF,
                              32'h00800000, 32'hFF800000, 32'h40000000, 32'h80000000,
                              32'h7F800001};
  logic [31:0] dir_b [13] = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h3F800000,
                              32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F000000,
                              32'h40000000, 32'h40000000, 32'hFF800000, 32'h40000000,
                              32'h3F800000};
  logic [31:0] dir_o [13] = '{32'h40400000, 32'hBE800000, 32'h3EAAAAAB, 32'h3F800000,
                              32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000,
                              32'h00000000, 32'hFF800000, 32'h80000000, 32'h80000000,
                              32'h7FC00000};
  logic [3:0]  dir_f [13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b1000,
                              4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000};

  initial begin
    logic [31:0] ra, rb, ro, o1, o2;
    logic [3:0]  rf, f1, f2;
    int          d1, d2, done_cnt;

    rst = 1'b1; start = 1'b0; in0 = 32'd0; in1 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_op(dir_a[i], dir_b[i], dir_o[i], dir_f[i], $sformatf("dir%0d", i));
    end

    for (int i = 0; i < 150; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      ref_div(ra, rb, ro, rf);
      run_op(ra, rb, ro, rf, $sformatf("rnd%0d_%h_%h", i, ra, rb));
    end

    // Starts during the operation and in its done cycle are ignored; T+30 is accepted.
    start = 1'b1; in0 = 32'h3F800000; in1 = 32'h40400000;
    @(posedge clk);
    d1 = 0; d2 = 0; done_cnt = 0; o1 = 0; o2 = 0; f1 = 0; f2 = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (d1 == 0) begin d1 = c; o1 = out; f1 = flags; end
        else begin d2 = c; o2 = out; f2 = flags; end
      end
      if (c == 30) check("ign_busy_t30", {31'd0, busy}, 32'd0);
      if (c == 40) check("ign_out_held", out, 32'h3EAAAAAB);
      start = (c == 5) || (c == 29) || (c == 30);
      if (c == 1) begin in0 = $urandom; in1 = $urandom; end
      if (c == 5) begin in0 = 32'h40C00000; in1 = 32'h40000000; end
      if (c == 29) begin in0 = 32'hBF800000; in1 = 32'h40800000; end
    end
    check("ign_done_cnt", 32'(done_cnt), 32'd2);
    check("ign_d1", 32'(d1), 32'd29);
    check("ign_out1", o1, 32'h3EAAAAAB);
    check("ign_flags1", {28'd0, f1}, 32'd0);
    check("ign_d2", 32'(d2), 32'd59);
    check("ign_out2", o2, 32'hBE800000);
    check("ign_flags2", {28'd0, f2}, 32'd0);

    // Reset mid-operation aborts it; a start coinciding with rst is dropped.
    start = 1'b1; in0 = 32'h40C00000; in1 = 32'h40000000;
    @(posedge clk);
    d1 = 0; done_cnt = 0; o1 = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) begin done_cnt++; d1 = c; o1 = out; end
      if (c == 11) begin
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out", out, 32'd0);
        check("abort_flags", {28'd0, flags}, 32'd0);
      end
      if (c == 12) check("abort_no_start", {31'd0, busy}, 32'd0);
      start = (c == 10) || (c == 12);
      rst   = (c == 10);
      if (c == 2) begin in0 = $urandom; in1 = $urandom; end
      if (c == 10) begin in0 = 32'h40000000; in1 = 32'h40000000; end
      if (c == 12) begin in0 = 32'h3F800000; in1 = 32'h3F800000; end
    end
    check("abort_done_cnt", 32'(done_cnt), 32'd1);
    check("abort_d", 32'(d1), 32'd41);
    check("abort_out_new", o1, 32'h3F800000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp32_divider.md
# fp32_divider

Iterative IEEE-754 single-precision divider computing in0 / in1 with a start/busy/done handshake. It is the division counterpart of the team's 32-bit FP multiplier and shares its operand/result encoding and port style. The mantissa quotient is produced by a radix-2 restoring divider, one bit per cycle, and rounded to nearest-even. Latency is fixed for every operand class.

## Interface
- No parameters; widths fixed for binary32.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- in0  input  32  dividend, IEEE-754 binary32
- in1  input  32  divisor, IEEE-754 binary32
- busy  output  1  high from the cycle after acceptance through the cycle done is high
- done  output  1  one-cycle pulse; out/flags valid in that cycle
- out  output  32  quotient; held until next done
- flags  output  4  {inv, dz, ovf, unf}; held with out

## Operation
- States: IDLE -> UNPACK -> DIVIDE (26 cycles, counter 25..0) -> ROUND -> DONE -> IDLE.
- IDLE: on start=1, latch in0/in1, go to UNPACK. start while busy=1 is ignored (no queueing).
- UNPACK:
  - sign = s0 ^ s1.
  - exp = e0 - e1 + 127 in a 10-bit signed register.
  - Mantissas ma/mb = {1, frac}.
  - Exponent field 0 means zero; denormals are flushed, sign kept.
  - Classify the special case.
- DIVIDE: remainder r starts at ma. Each cycle compute r - mb: if non-negative, take quotient bit 1 and r := 2*(r - mb), else bit 0 and r := 2*r. Result q26 = floor(ma*2^25/mb).
- ROUND:
  - If q26[25]=1: m = q26[25:2], guard = q26[1], sticky = q26[0] | (r != 0).
  - Else: exp -= 1, m = q26[24:1], guard = q26[0], sticky = (r != 0).
  - Round up when guard & (sticky | m[0]). On carry to 2^24: m >>= 1, exp += 1.
  - exp >= 255: signed infinity, ovf=1.
  - exp <= 0: signed zero, unf=1.
  - Otherwise out = {sign, exp[7:0], m[22:0]}.
- Special cases bypass the arithmetic result but keep the same latency. Priority, highest first:
  1. Either operand NaN, 0/0, or inf/inf: out=0x7FC00000, inv=1.
  2. inf/x: signed inf.
  3. x/inf: signed zero.
  4. x/0 (x finite, nonzero): signed inf, dz=1.
  5. 0/x: signed zero.
- Flags not raised by the selected case are 0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, out=0x00000000, flags=0.
- Accept at cycle T (start=1, busy=0). busy=1 in T+1..T+29, done=1 in T+29 only, busy=0 in T+30.
- Latency from acceptance to done is 29 cycles for all operands, including special cases.
- A new start is accepted earliest at T+30. start=1 in T+29 is ignored.
- Back-to-back operation: one result per 30 cycles.
- out/flags update only in the done cycle and are stable otherwise.
- Changing in0/in1 after acceptance does not affect the operation in flight.
- rst=1 in any state: next cycle IDLE with all outputs at reset values. The aborted operation produces no done.
- rst and start in the same cycle: rst wins and the request is dropped.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> done at T+29, out=0x40400000, flags=0. Also 0xBF800000 / 0x40800000 -> 0xBE800000.
- 0x3F800000 / 0x40400000 (1/3) -> out=0x3EAAAAAB (round-up path). Also 0x3F800000 / 0x3F800000 -> 0x3F800000.
- 0x3F800000 / 0x00000000 -> 0x7F800000, dz=1. 0x00000000 / 0x00000000 -> 0x7FC00000, inv=1. 0x7F800000 / 0x7F800000 -> 0x7FC00000, inv=1.
- 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, ovf=1. 0x00800000 / 0x40000000 -> 0x00000000, unf=1.
- Assert start again at T+5 and T+29 with different operands -> both ignored; the first result is unchanged. Start at T+30 -> accepted, done at T+59.
- rst=1 at T+10 -> done never pulses, out=0 and busy=0 from T+11. A new start at T+12 completes normally at T+41.
